// File: rtl/popcount_window_stats_pkg.sv
// Shared types and constants for the popcount window statistics block.
package popcount_window_stats_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int POP_MAX = 16;

    // Minimum sum width able to hold WIN_LEN samples of POP_MAX each.
    function automatic int sum_width(input int win_len);
        return $clog2(POP_MAX * win_len + 1);
    endfunction

endpackage

// File: rtl/popcount_window_stats_if.sv
// Sample/result stream bundle between a producer/consumer and the stats block.
interface popcount_window_stats_if #(
    parameter int CNT_W = 6,
    parameter int SUM_W = 10
);
    logic             clr;
    logic             in_valid;
    logic [CNT_W-1:0] in_count;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] sum_out;
    logic [CNT_W-1:0] min_out;
    logic [CNT_W-1:0] max_out;
    logic             err;

    modport master (
        output clr, in_valid, in_count, out_ready,
        input  in_ready, out_valid, sum_out, min_out, max_out, err
    );

    modport slave (
        input  clr, in_valid, in_count, out_ready,
        output in_ready, out_valid, sum_out, min_out, max_out, err
    );
endinterface

// File: rtl/popcount_window_stats_minmax.sv
// Clamps one popcount sample to POP_MAX and folds it into the running min/max.
module popcount_minmax
    import popcount_window_stats_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic [CNT_W-1:0] sample,
    input  logic             first,
    input  logic [CNT_W-1:0] min_cur,
    input  logic [CNT_W-1:0] max_cur,
    output logic [CNT_W-1:0] clamped,
    output logic [CNT_W-1:0] min_next,
    output logic [CNT_W-1:0] max_next,
    output logic             over
);
    localparam logic [CNT_W-1:0] POP_MAX_C = CNT_W'(POP_MAX);

    always_comb begin
        over     = sample > POP_MAX_C;
        clamped  = over ? POP_MAX_C : sample;
        // The first sample of a window replaces whatever the previous window left.
        min_next = (first || clamped < min_cur) ? clamped : min_cur;
        max_next = (first || clamped > max_cur) ? clamped : max_cur;
    end
endmodule

// File: rtl/popcount_window_stats.sv
// Collects WIN_LEN popcount samples and presents their sum/min/max on a
// valid/ready result port; a sticky err marks any out-of-range sample.
module popcount_window_stats
    import popcount_window_stats_pkg::*;
#(
    parameter int WIN_LEN = 8,
    parameter int CNT_W   = 6,
    parameter int SUM_W   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    popcount_window_stats_if.slave  bus
);
    localparam int IDX_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIN_LEN - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [SUM_W-1:0] sum_reg, sum_next, sum_out_reg;
    logic [CNT_W-1:0] min_reg, max_reg, min_next, max_next, clamped;
    logic [CNT_W-1:0] min_out_reg, max_out_reg;
    logic             err_reg, over, accept, first, last;
    logic             in_ready, out_valid;

    assign accept = bus.in_valid && in_ready;
    assign first  = (idx_reg == '0);
    assign last   = (idx_reg == IDX_LAST);

    popcount_minmax #(.CNT_W(CNT_W)) u_minmax (
        .sample   (bus.in_count),
        .first    (first),
        .min_cur  (min_reg),
        .max_cur  (max_reg),
        .clamped  (clamped),
        .min_next (min_next),
        .max_next (max_next),
        .over     (over)
    );

    assign sum_next = first ? SUM_W'(clamped) : sum_reg + SUM_W'(clamped);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ACCUM;
        else     state_reg <= state_next;
    end

    // clr outranks both the closing accept and the result handshake.
    always_comb begin
        state_next = state_reg;
        if (bus.clr) begin
            state_next = ACCUM;
        end else begin
            case (state_reg)
                ACCUM:   if (accept && last)   state_next = HOLD;
                HOLD:    if (bus.out_ready)    state_next = ACCUM;
                default:                       state_next = ACCUM;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_reg == ACCUM) && !bus.clr;
        out_valid = (state_reg == HOLD);
    end

    // Result registers only move on the closing accept; clr drops the
    // window in progress but leaves the last published result in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg     <= '0;
            sum_reg     <= '0;
            min_reg     <= '0;
            max_reg     <= '0;
            err_reg     <= 1'b0;
            sum_out_reg <= '0;
            min_out_reg <= '0;
            max_out_reg <= '0;
        end else if (bus.clr) begin
            idx_reg <= '0;
            sum_reg <= '0;
            min_reg <= '0;
            max_reg <= '0;
            err_reg <= 1'b0;
        end else if (accept) begin
            idx_reg <= last ? '0 : idx_reg + IDX_W'(1);
            sum_reg <= sum_next;
            min_reg <= min_next;
            max_reg <= max_next;
            if (over) err_reg <= 1'b1;
            if (last) begin
                sum_out_reg <= sum_next;
                min_out_reg <= min_next;
                max_out_reg <= max_next;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum_out   = sum_out_reg;
    assign bus.min_out   = min_out_reg;
    assign bus.max_out   = max_out_reg;
    assign bus.err       = err_reg;
endmodule

// File: tb/tb_popcount_window_stats.sv
// Scoreboard bench: a WIN_LEN=4 instance driven through windows, stalls, clr
// and reset, plus a WIN_LEN=1 instance for single-sample windows.
module tb_popcount_window_stats;
    import popcount_window_stats_pkg::*;

    localparam int CNT_W = 6;
    localparam int SUM_W = sum_width(64);
    localparam int WIN_A = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    popcount_window_stats_if #(.CNT_W(CNT_W), .SUM_W(SUM_W)) a_if ();
    popcount_window_stats_if #(.CNT_W(CNT_W), .SUM_W(SUM_W)) b_if ();

    popcount_window_stats #(.WIN_LEN(WIN_A), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    popcount_window_stats #(.WIN_LEN(1), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    typedef struct {
        int s;
        int mn;
        int mx;
    } exp_t;

    exp_t sb_q[$];
    int   checks_cnt = 0;
    int   fail_cnt   = 0;
    int   m_idx = 0, m_sum = 0, m_min = 0, m_max = 0;
    bit   push_en = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drive one sample into instance A and fold it into the reference window.
    task automatic send_a(input int v);
        int n;
        int cl;
        n = 0;
        while (a_if.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check_val("a_ready_timeout", 0, 1);
        a_if.in_valid = 1'b1;
        a_if.in_count = CNT_W'(v);
        step();
        a_if.in_valid = 1'b0;
        $display("a accept sample=%0d", v);
        cl = (v > POP_MAX) ? POP_MAX : v;
        if (m_idx == 0) begin
            m_sum = cl; m_min = cl; m_max = cl;
        end else begin
            m_sum += cl;
            if (cl < m_min) m_min = cl;
            if (cl > m_max) m_max = cl;
        end
        m_idx++;
        if (m_idx == WIN_A) begin
            m_idx = 0;
            if (push_en) sb_q.push_back('{s: m_sum, mn: m_min, mx: m_max});
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && a_if.out_valid === 1'b1 && a_if.out_ready === 1'b1 && a_if.clr === 1'b0) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_result", 1, 0);
            end else begin
                e = sb_q.pop_front();
                $display("a result sum=%0d min=%0d max=%0d", a_if.sum_out, a_if.min_out, a_if.max_out);
                check_val("sb_sum", 32'(a_if.sum_out), e.s);
                check_val("sb_min", 32'(a_if.min_out), e.mn);
                check_val("sb_max", 32'(a_if.max_out), e.mx);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_if.clr = 1'b0; a_if.in_valid = 1'b0; a_if.in_count = '0; a_if.out_ready = 1'b1;
        b_if.clr = 1'b0; b_if.in_valid = 1'b0; b_if.in_count = '0; b_if.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", 32'(a_if.out_valid), 0);
        check_val("rst_in_ready", 32'(a_if.in_ready), 1);
        check_val("rst_sum", 32'(a_if.sum_out), 0);
        check_val("rst_err", 32'(a_if.err), 0);
        step();
        rst = 1'b0;

        // Basic window 3,16,0,7 with the consumer always ready.
        send_a(3); send_a(16); send_a(0); send_a(7);
        @(negedge clk);
        check_val("w1_out_valid", 32'(a_if.out_valid), 1);
        check_val("w1_sum", 32'(a_if.sum_out), 26);
        check_val("w1_min", 32'(a_if.min_out), 0);
        check_val("w1_max", 32'(a_if.max_out), 16);
        check_val("w1_err", 32'(a_if.err), 0);
        step();
        @(negedge clk);
        check_val("w1_drop_valid", 32'(a_if.out_valid), 0);

        // Same window held for 5 cycles against in_valid pulses.
        step();
        a_if.out_ready = 1'b0;
        send_a(3); send_a(16); send_a(0); send_a(7);
        for (int i = 0; i < 5; i++) begin
            a_if.in_valid = i[0];
            a_if.in_count = CNT_W'(5 + i);
            @(negedge clk);
            check_val("hold_valid", 32'(a_if.out_valid), 1);
            check_val("hold_in_ready", 32'(a_if.in_ready), 0);
            check_val("hold_sum", 32'(a_if.sum_out), 26);
            check_val("hold_min", 32'(a_if.min_out), 0);
            check_val("hold_max", 32'(a_if.max_out), 16);
            step();
        end
        a_if.in_valid = 1'b0;
        a_if.out_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        check_val("hold_release_valid", 32'(a_if.out_valid), 0);
        check_val("hold_release_ready", 32'(a_if.in_ready), 1);

        // Out-of-range sample: clamp and sticky err.
        step();
        send_a(20);
        @(negedge clk);
        check_val("err_set", 32'(a_if.err), 1);
        send_a(1); send_a(1); send_a(1);
        @(negedge clk);
        check_val("err_sum", 32'(a_if.sum_out), 19);
        check_val("err_max", 32'(a_if.max_out), 16);
        check_val("err_min", 32'(a_if.min_out), 1);
        step();
        @(negedge clk);
        check_val("err_sticky", 32'(a_if.err), 1);
        step();
        a_if.clr = 1'b1;
        step();
        a_if.clr = 1'b0;
        m_idx = 0;
        @(negedge clk);
        check_val("err_cleared", 32'(a_if.err), 0);

        // Asynchronous reset mid-window, then a fresh window.
        step();
        send_a(2); send_a(2);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_sum", 32'(a_if.sum_out), 0);
        check_val("arst_min", 32'(a_if.min_out), 0);
        check_val("arst_max", 32'(a_if.max_out), 0);
        check_val("arst_valid", 32'(a_if.out_valid), 0);
        check_val("arst_err", 32'(a_if.err), 0);
        step();
        rst = 1'b0;
        m_idx = 0;
        send_a(2); send_a(2); send_a(2); send_a(2);
        @(negedge clk);
        check_val("post_rst_sum", 32'(a_if.sum_out), 8);
        step();

        // clr against a HOLD handshake, then against an ACCUM sample.
        a_if.out_ready = 1'b0;
        push_en = 1'b0;
        send_a(4); send_a(5); send_a(6); send_a(7);
        @(negedge clk);
        check_val("clr_hold_valid", 32'(a_if.out_valid), 1);
        step();
        a_if.clr = 1'b1;
        a_if.out_ready = 1'b1;
        step();
        a_if.clr = 1'b0;
        @(negedge clk);
        check_val("clr_hold_drop", 32'(a_if.out_valid), 0);
        check_val("clr_hold_ready", 32'(a_if.in_ready), 1);
        push_en = 1'b1;
        step();
        send_a(1); send_a(1);
        a_if.clr = 1'b1;
        a_if.in_valid = 1'b1;
        a_if.in_count = CNT_W'(9);
        step();
        a_if.clr = 1'b0;
        a_if.in_valid = 1'b0;
        m_idx = 0;
        @(negedge clk);
        check_val("clr_accum_valid", 32'(a_if.out_valid), 0);
        send_a(1); send_a(2); send_a(3); send_a(4);
        @(negedge clk);
        check_val("clr_accum_valid_win", 32'(a_if.out_valid), 1);
        check_val("clr_accum_sum", 32'(a_if.sum_out), 10);
        step();

        // Single-sample windows on the WIN_LEN=1 instance.
        b_if.in_valid = 1'b1;
        b_if.in_count = CNT_W'(5);
        step();
        b_if.in_valid = 1'b0;
        $display("b accept sample=5");
        @(negedge clk);
        check_val("b1_valid", 32'(b_if.out_valid), 1);
        check_val("b1_sum", 32'(b_if.sum_out), 5);
        check_val("b1_min", 32'(b_if.min_out), 5);
        check_val("b1_max", 32'(b_if.max_out), 5);
        step();
        @(negedge clk);
        check_val("b1_drop", 32'(b_if.out_valid), 0);
        step();
        b_if.in_valid = 1'b1;
        b_if.in_count = CNT_W'(9);
        step();
        b_if.in_valid = 1'b0;
        $display("b accept sample=9");
        @(negedge clk);
        check_val("b2_valid", 32'(b_if.out_valid), 1);
        check_val("b2_sum", 32'(b_if.sum_out), 9);
        check_val("b2_min", 32'(b_if.min_out), 9);
        check_val("b2_max", 32'(b_if.max_out), 9);

        repeat (3) step();
        check_val("sb_empty", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end
endmodule
